// File: rtl/cpu_ce_gen.sv
// Clock-enable generator for the Specialist/MX core.
// Derives CPU f1/f2, timer and pixel strobes from clk_sys.
module cpu_ce_gen #(
  parameter int CPU_DIV   = 48,
  parameter int F2_OFS    = 12,
  parameter int SPEEDS    = 2,
  parameter int PIX_DIV   = 12,
  parameter int PIX_N_OFS = 6
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic [1:0] speed,
  input  logic       stall,
  output logic       ce_f1,
  output logic       ce_f2,
  output logic       ce_pit,
  output logic       ce_pix_p,
  output logic       ce_pix_n,
  output logic [1:0] speed_cur,
  output logic       skipped
);

  localparam int CW = $clog2(CPU_DIV);
  localparam int PW = $clog2(PIX_DIV);

  typedef enum logic [1:0] {
    IDLE,
    PAIR,
    SKIP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cpu_cnt_q, cpu_cnt_d;
  logic [PW-1:0] pix_cnt_q, pix_cnt_d;
  logic [1:0]    speed_cur_q, speed_cur_d;
  logic [1:0]    speed_req;
  logic [CW-1:0] slot_ofs;
  logic          f1_slot, f2_slot;
  logic          ce_f1_q, ce_f1_d;
  logic          ce_f2_q, ce_f2_d;
  logic          ce_pit_q, ce_pit_d;
  logic          ce_pix_p_q, ce_pix_p_d;
  logic          ce_pix_n_q, ce_pix_n_d;
  logic          skipped_q, skipped_d;

  // Free-running dividers, clamped speed latch and slot position.
  always_comb begin
    cpu_cnt_d = cpu_cnt_q + CW'(1);
    if (cpu_cnt_q == CW'(CPU_DIV - 1))
      cpu_cnt_d = '0;
    pix_cnt_d = pix_cnt_q + PW'(1);
    if (pix_cnt_q == PW'(PIX_DIV - 1))
      pix_cnt_d = '0;
    speed_req = speed;
    if (int'(speed) > SPEEDS - 1)
      speed_req = 2'(SPEEDS - 1);
    speed_cur_d = speed_cur_q;
    if (cpu_cnt_q == CW'(CPU_DIV - 1))
      speed_cur_d = speed_req;
    slot_ofs = cpu_cnt_q;
    for (int m = 0; m < SPEEDS; m++) begin
      if (speed_cur_q == 2'(m))
        slot_ofs = CW'({1'b0, cpu_cnt_q} %
                       (CW + 1)'(CPU_DIV >> m));
    end
    f1_slot = (slot_ofs == '0);
    f2_slot = (slot_ofs == CW'(F2_OFS));
  end

  // Pair FSM: stall sampled only at f1, so a pair is never split.
  always_comb begin
    state_d    = state_q;
    ce_f1_d    = 1'b0;
    ce_f2_d    = 1'b0;
    skipped_d  = 1'b0;
    ce_pit_d   = (cpu_cnt_q == '0);
    ce_pix_p_d = (pix_cnt_q == '0);
    ce_pix_n_d = (pix_cnt_q == PW'(PIX_N_OFS));
    unique case (state_q)
      IDLE: begin
        if (f1_slot) begin
          if (stall) begin
            skipped_d = 1'b1;
            state_d   = SKIP;
          end else begin
            ce_f1_d = 1'b1;
            state_d = PAIR;
          end
        end
      end
      PAIR: begin
        if (f2_slot) begin
          ce_f2_d = 1'b1;
          state_d = IDLE;
        end
      end
      SKIP: begin
        if (f2_slot)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered strobes; reset abandons any open pair.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= IDLE;
      cpu_cnt_q   <= '0;
      pix_cnt_q   <= '0;
      speed_cur_q <= '0;
      ce_f1_q     <= 1'b0;
      ce_f2_q     <= 1'b0;
      ce_pit_q    <= 1'b0;
      ce_pix_p_q  <= 1'b0;
      ce_pix_n_q  <= 1'b0;
      skipped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cpu_cnt_q   <= cpu_cnt_d;
      pix_cnt_q   <= pix_cnt_d;
      speed_cur_q <= speed_cur_d;
      ce_f1_q     <= ce_f1_d;
      ce_f2_q     <= ce_f2_d;
      ce_pit_q    <= ce_pit_d;
      ce_pix_p_q  <= ce_pix_p_d;
      ce_pix_n_q  <= ce_pix_n_d;
      skipped_q   <= skipped_d;
    end
  end

  assign ce_f1     = ce_f1_q;
  assign ce_f2     = ce_f2_q;
  assign ce_pit    = ce_pit_q;
  assign ce_pix_p  = ce_pix_p_q;
  assign ce_pix_n  = ce_pix_n_q;
  assign speed_cur = speed_cur_q;
  assign skipped   = skipped_q;

endmodule

// File: tb/tb_cpu_ce_gen.sv
// Bench for cpu_ce_gen: count table, corner sequences,
// random stimulus against an event-scheduling model.
module tb_cpu_ce_gen;

  localparam int CPU_DIV   = 48;
  localparam int F2_OFS    = 12;
  localparam int SPEEDS    = 2;
  localparam int PIX_DIV   = 12;
  localparam int PIX_N_OFS = 6;

  logic       clk_sys = 1'b0;
  logic       reset   = 1'b1;
  logic [1:0] speed   = 2'd0;
  logic       stall   = 1'b0;
  logic       ce_f1, ce_f2, ce_pit, ce_pix_p, ce_pix_n;
  logic [1:0] speed_cur;
  logic       skipped;

  always #5 clk_sys = ~clk_sys;

  cpu_ce_gen #(
    .CPU_DIV  (CPU_DIV),
    .F2_OFS   (F2_OFS),
    .SPEEDS   (SPEEDS),
    .PIX_DIV  (PIX_DIV),
    .PIX_N_OFS(PIX_N_OFS)
  ) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .speed    (speed),
    .stall    (stall),
    .ce_f1    (ce_f1),
    .ce_f2    (ce_f2),
    .ce_pit   (ce_pit),
    .ce_pix_p (ce_pix_p),
    .ce_pix_n (ce_pix_n),
    .speed_cur(speed_cur),
    .skipped  (skipped)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: time-indexed, f2 scheduled as absolute cycle.
  int m_cnt = 0, m_pix = 0, m_spd = 0, cyc = 0;
  int due[$];
  int e_f1, e_f2, e_pit, e_pixp, e_pixn, e_skip;

  int t_f1, t_f2, t_pit, t_pixp, t_pixn, t_skip;

  typedef struct {
    bit         rst;
    logic [1:0] spd;
    bit         stl;
    int         n;
    int         f1, f2, pit, pixp, pixn, skip;
    int         spd_end;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t",
               name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    int len;
    if (reset) begin
      {e_f1, e_f2, e_pit} = '0;
      {e_pixp, e_pixn, e_skip} = '0;
      m_cnt = 0;
      m_pix = 0;
      m_spd = 0;
      due.delete();
    end else begin
      len    = CPU_DIV >> m_spd;
      e_pit  = int'(m_cnt == 0);
      e_pixp = int'(m_pix == 0);
      e_pixn = int'(m_pix == PIX_N_OFS);
      e_f1   = 0;
      e_f2   = 0;
      e_skip = 0;
      if (due.size() > 0 && due[0] == cyc) begin
        e_f2 = 1;
        void'(due.pop_front());
      end
      if (m_cnt % len == 0) begin
        if (stall) e_skip = 1;
        else begin
          e_f1 = 1;
          due.push_back(cyc + F2_OFS);
        end
      end
      if (m_cnt == CPU_DIV - 1)
        m_spd = (int'(speed) > SPEEDS - 1) ?
                SPEEDS - 1 : int'(speed);
      m_cnt = (m_cnt + 1) % CPU_DIV;
      m_pix = (m_pix + 1) % PIX_DIV;
    end
    cyc++;
  endtask

  task automatic tally_clr();
    {t_f1, t_f2, t_pit} = '0;
    {t_pixp, t_pixn, t_skip} = '0;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk_sys);
    #1;
    chk("ce_f1", int'(ce_f1), e_f1);
    chk("ce_f2", int'(ce_f2), e_f2);
    chk("ce_pit", int'(ce_pit), e_pit);
    chk("ce_pix_p", int'(ce_pix_p), e_pixp);
    chk("ce_pix_n", int'(ce_pix_n), e_pixn);
    chk("skipped", int'(skipped), e_skip);
    chk("speed_cur", int'(speed_cur), m_spd);
    t_f1   += int'(ce_f1);
    t_f2   += int'(ce_f2);
    t_pit  += int'(ce_pit);
    t_pixp += int'(ce_pix_p);
    t_pixn += int'(ce_pix_n);
    t_skip += int'(skipped);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    tbl[0] = '{1, 2'd0, 0, 3, 0, 0, 0, 0, 0, 0, 0};
    tbl[1] = '{0, 2'd0, 0, 96, 2, 2, 2, 8, 8, 0, 0};
    tbl[2] = '{0, 2'd1, 0, 96, 3, 3, 2, 8, 8, 0, 1};
    tbl[3] = '{0, 2'd1, 1, 48, 0, 0, 1, 4, 4, 2, 1};
    tbl[4] = '{0, 2'd3, 0, 96, 4, 4, 2, 8, 8, 0, 1};
    tbl[5] = '{0, 2'd0, 0, 96, 3, 3, 2, 8, 8, 0, 0};

    for (int r = 0; r < 6; r++) begin
      reset = tbl[r].rst;
      speed = tbl[r].spd;
      stall = tbl[r].stl;
      tally_clr();
      steps(tbl[r].n);
      chk($sformatf("row%0d_f1", r), t_f1, tbl[r].f1);
      chk($sformatf("row%0d_f2", r), t_f2, tbl[r].f2);
      chk($sformatf("row%0d_pit", r), t_pit, tbl[r].pit);
      chk($sformatf("row%0d_pixp", r), t_pixp, tbl[r].pixp);
      chk($sformatf("row%0d_pixn", r), t_pixn, tbl[r].pixn);
      chk($sformatf("row%0d_skip", r), t_skip, tbl[r].skip);
      chk($sformatf("row%0d_spd", r), int'(speed_cur),
          tbl[r].spd_end);
    end

    // Speed 0->1 requested mid-period takes effect at wrap.
    speed = 2'd0;
    for (int i = 0; i < CPU_DIV && m_cnt != 10; i++) step();
    speed = 2'd1;
    tally_clr();
    steps(CPU_DIV - 10);
    chk("midchg_no_extra_f1", t_f1, 0);
    chk("midchg_speed_cur", int'(speed_cur), 1);
    tally_clr();
    steps(CPU_DIV);
    chk("midchg_double_f1", t_f1, 2);
    speed = 2'd0;
    steps(CPU_DIV);

    // One-cycle stall exactly at f1 suppresses the whole pair.
    stall = 1'b1;
    step();
    chk("stall_f1", int'(ce_f1), 0);
    chk("stall_skipped", int'(skipped), 1);
    stall = 1'b0;
    tally_clr();
    steps(CPU_DIV - 1);
    chk("stall_no_f2", t_f2, 0);
    chk("stall_skip_once", t_skip, 0);

    // Stall between f1 and f2 does not split the pair.
    step();
    chk("midstall_f1", int'(ce_f1), 1);
    stall = 1'b1;
    tally_clr();
    steps(20);
    chk("midstall_f2", t_f2, 1);
    stall = 1'b0;
    steps(CPU_DIV - 21);

    // Reset 5 cycles after f1 abandons the pair.
    step();
    chk("rst_pre_f1", int'(ce_f1), 1);
    steps(5);
    reset = 1'b1;
    tally_clr();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_outs_zero",
          int'({ce_f1, ce_f2, ce_pit, ce_pix_p,
                ce_pix_n, skipped, speed_cur}), 0);
    end
    chk("rst_no_f2", t_f2, 0);
    reset = 1'b0;
    step();
    chk("rel_f1", int'(ce_f1), 1);
    chk("rel_pit", int'(ce_pit), 1);
    chk("rel_pixp", int'(ce_pix_p), 1);
    tally_clr();
    steps(30);
    chk("rel_f2", t_f2, 1);

    // Random speed/stall/reset against the model.
    for (int i = 0; i < 3000; i++) begin
      speed = 2'($urandom_range(0, 3));
      stall = ($urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 1'b0;
    stall = 1'b0;
    steps(CPU_DIV);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
